// File: rtl/impl_delay_monitor_pkg.sv
// Shared constants and result type for the delayed-implication monitor.
package impl_delay_monitor_pkg;
  localparam int MAX_DELAY = 31;
  localparam int STAMP_W   = 32;

  typedef struct packed {
    logic pass;
    logic fail;
  } mon_result_t;
endpackage

// File: rtl/impl_delay_monitor_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/impl_delay_monitor.sv
// Checks "a at edge k implies b at edge k+DELAY" with overlapping attempts.
// Optional start-edge stamp of the first failure: IMPL_DELAY_MONITOR_STAMP_EN.
module impl_delay_monitor
  import impl_delay_monitor_pkg::*;
#(
  parameter int DELAY = 4,
  parameter int CNT_W = 16
) (
`ifdef IMPL_DELAY_MONITOR_STAMP_EN
  output logic [STAMP_W-1:0] first_fail_start,
`endif
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             a,
  input  logic             b,
  input  logic             clr,
  output logic             pass,
  output logic             fail,
  output logic [DELAY-1:0] pending,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             any_fail
);
  logic [DELAY-1:0] pend;
  logic [DELAY-1:0] pend_next;
  logic             start;
  mon_result_t      res;

  assign start = en & a;

  generate
    if (DELAY == 1) begin : g_pend_one
      assign pend_next = start;
    end else begin : g_pend_shift
      assign pend_next = {pend[DELAY-2:0], start};
    end
  endgenerate

  // Only the oldest attempt looks at b; clr also drops the attempt sampled now.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      pend     <= '0;
      res      <= '0;
      any_fail <= 1'b0;
    end else begin
      pend     <= pend_next;
      res.pass <= pend[DELAY-1] & b;
      res.fail <= pend[DELAY-1] & ~b;
      if (res.fail) begin
        any_fail <= 1'b1;
      end
    end
  end

  assign pass    = res.pass;
  assign fail    = res.fail;
  assign pending = pend;

  sat_counter #(.W(CNT_W)) u_pass_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (res.pass),
    .clr   (clr),
    .cnt   (pass_cnt)
  );

  sat_counter #(.W(CNT_W)) u_fail_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (res.fail),
    .clr   (clr),
    .cnt   (fail_cnt)
  );

`ifdef IMPL_DELAY_MONITOR_STAMP_EN
  logic [STAMP_W-1:0] cyc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc <= '0;
    end else begin
      cyc <= cyc + 1'b1;
    end
  end

  // Latched one edge after the fail pulse, so the start edge is DELAY+1 back.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      first_fail_start <= '0;
    end else if (res.fail && !any_fail) begin
      first_fail_start <= cyc - STAMP_W'(DELAY + 1);
    end
  end
`endif
endmodule

// File: tb/tb_impl_delay_monitor.sv
// Directed bench for impl_delay_monitor: a DELAY=4 instance and a DELAY=2, CNT_W=3 instance.
module tb_impl_delay_monitor;
  logic       clk = 1'b0;
  logic       rst_n, en, a, b, clr;
  logic       pass, fail, any_fail;
  logic [3:0] pending;
  logic [15:0] pass_cnt, fail_cnt;
  logic       pass_s, fail_s, any_fail_s;
  logic [1:0] pending_s;
  logic [2:0] pass_cnt_s, fail_cnt_s;
`ifdef IMPL_DELAY_MONITOR_STAMP_EN
  logic [31:0] ffs, ffs_s;
`endif
  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  impl_delay_monitor #(.DELAY(4), .CNT_W(16)) dut (
`ifdef IMPL_DELAY_MONITOR_STAMP_EN
    .first_fail_start (ffs),
`endif
    .clk (clk), .rst_n (rst_n), .en (en), .a (a), .b (b), .clr (clr),
    .pass (pass), .fail (fail), .pending (pending),
    .pass_cnt (pass_cnt), .fail_cnt (fail_cnt), .any_fail (any_fail)
  );

  impl_delay_monitor #(.DELAY(2), .CNT_W(3)) dut_s (
`ifdef IMPL_DELAY_MONITOR_STAMP_EN
    .first_fail_start (ffs_s),
`endif
    .clk (clk), .rst_n (rst_n), .en (en), .a (a), .b (b), .clr (clr),
    .pass (pass_s), .fail (fail_s), .pending (pending_s),
    .pass_cnt (pass_cnt_s), .fail_cnt (fail_cnt_s), .any_fail (any_fail_s)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear;
    clr = 1'b1; a = 1'b0; b = 1'b0; en = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; en = 1'b1; a = 1'b1; b = 1'b1; clr = 1'b0;
    tick(); tick();
    checks++;
    if ({pass, fail, pending, pass_cnt, fail_cnt, any_fail} !== 39'd0)
      $display("FAIL reset_dut got %b want 0", {pass, fail, pending, pass_cnt, fail_cnt, any_fail});
    else passed++;
    checks++;
    if ({pass_s, fail_s, pending_s, pass_cnt_s, fail_cnt_s, any_fail_s} !== 11'd0)
      $display("FAIL reset_dut_s got %b want 0", {pass_s, fail_s, pending_s, pass_cnt_s, fail_cnt_s, any_fail_s});
    else passed++;
    rst_n = 1'b1;
    do_clear();
  endtask

  task automatic test_overlap;
    logic [11:0] exp_p, exp_f;
    exp_p = 12'b000011000000;
    exp_f = 12'b001100110000;
    do_clear();
    for (int e = 0; e < 12; e++) begin
      en = 1'b1; a = (e <= 5); b = (e == 6 || e == 7);
      tick();
      checks++;
      if ({pass, fail} !== {exp_p[e], exp_f[e]})
        $display("FAIL overlap_pulse e=%0d got %b%b want %b%b", e, pass, fail, exp_p[e], exp_f[e]);
      else passed++;
    end
    checks++;
    if (pass_cnt !== 16'd2) $display("FAIL overlap_pass_cnt got %0d want 2", pass_cnt);
    else passed++;
    checks++;
    if (fail_cnt !== 16'd4) $display("FAIL overlap_fail_cnt got %0d want 4", fail_cnt);
    else passed++;
    checks++;
    if (any_fail !== 1'b1) $display("FAIL overlap_any_fail got %b want 1", any_fail);
    else passed++;
  endtask

  task automatic test_single;
    logic [3:0] exp_pend;
    do_clear();
    for (int e = 0; e < 9; e++) begin
      en = 1'b1; a = (e == 3); b = (e == 7);
      tick();
      exp_pend = (e >= 3 && e <= 6) ? (4'b0001 << (e - 3)) : 4'b0000;
      checks++;
      if (pending !== exp_pend) $display("FAIL single_pending e=%0d got %b want %b", e, pending, exp_pend);
      else passed++;
      checks++;
      if ({pass, fail} !== {(e == 7), 1'b0})
        $display("FAIL single_pulse e=%0d got %b%b want %b0", e, pass, fail, (e == 7));
      else passed++;
    end
  endtask

  task automatic test_clr;
    do_clear();
    for (int e = 0; e < 12; e++) begin
      en = 1'b1; a = (e <= 2); b = 1'b1; clr = (e == 2);
      tick();
      if (e == 1) begin
        checks++;
        if (pending !== 4'b0011) $display("FAIL clr_pending_pre got %b want 0011", pending);
        else passed++;
      end
      if (e == 2) begin
        checks++;
        if (pending !== 4'b0000) $display("FAIL clr_pending got %b want 0000", pending);
        else passed++;
      end
      checks++;
      if ({pass, fail, pass_s, fail_s} !== 4'b0000)
        $display("FAIL clr_pulse e=%0d got %b%b%b%b want 0000", e, pass, fail, pass_s, fail_s);
      else passed++;
    end
    clr = 1'b0;
    checks++;
    if ({pass_cnt, fail_cnt, any_fail} !== 33'd0)
      $display("FAIL clr_counters got %0d/%0d/%b want 0/0/0", pass_cnt, fail_cnt, any_fail);
    else passed++;
  endtask

  task automatic test_enable;
    do_clear();
    en = 1'b0;
    for (int e = 0; e < 20; e++) begin
      a = e[0]; b = ($urandom_range(0, 1) == 1);
      tick();
      checks++;
      if ({pass, fail, pending} !== 6'd0)
        $display("FAIL en_block e=%0d got %b%b%b want 0", e, pass, fail, pending);
      else passed++;
    end
    for (int e = 0; e < 8; e++) begin
      en = (e == 0); a = 1'b1; b = (e == 4);
      tick();
      if (e == 1) begin
        checks++;
        if (pending !== 4'b0010) $display("FAIL en_inflight_pending got %b want 0010", pending);
        else passed++;
      end
      checks++;
      if ({pass, fail} !== {(e == 4), 1'b0})
        $display("FAIL en_inflight e=%0d got %b%b want %b0", e, pass, fail, (e == 4));
      else passed++;
    end
  endtask

  task automatic test_saturate;
    do_clear();
    for (int e = 0; e < 20; e++) begin
      en = 1'b1; a = (e < 12); b = 1'b1;
      tick();
    end
    checks++;
    if (pass_cnt_s !== 3'd7) $display("FAIL sat_pass_cnt got %0d want 7", pass_cnt_s);
    else passed++;
    checks++;
    if (fail_cnt_s !== 3'd0) $display("FAIL sat_fail_cnt got %0d want 0", fail_cnt_s);
    else passed++;
    checks++;
    if (pass_cnt !== 16'd12) $display("FAIL wide_pass_cnt got %0d want 12", pass_cnt);
    else passed++;
  endtask

  task automatic test_midflight_reset;
    do_clear();
    en = 1'b1; a = 1'b1; b = 1'b1;
    tick();
    a = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({pending, pending_s} !== 6'd0) $display("FAIL rst_mid_pending got %b%b want 0", pending, pending_s);
    else passed++;
    rst_n = 1'b1;
    for (int e = 0; e < 6; e++) begin
      tick();
      checks++;
      if ({pass, fail, pass_s, fail_s} !== 4'b0000)
        $display("FAIL rst_mid_pulse e=%0d got %b%b%b%b want 0000", e, pass, fail, pass_s, fail_s);
      else passed++;
    end
  endtask

`ifdef IMPL_DELAY_MONITOR_STAMP_EN
  task automatic test_stamp;
    rst_n = 1'b0; clr = 1'b0; en = 1'b1; a = 1'b0; b = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    for (int e = 0; e < 17; e++) begin
      a = (e == 10 || e == 11); b = 1'b0;
      tick();
      if (e >= 12 && e <= 14) begin
        checks++;
        if (ffs_s !== ((e == 12) ? 32'd0 : 32'd10))
          $display("FAIL stamp_s e=%0d got %0d want %0d", e, ffs_s, (e == 12) ? 0 : 10);
        else passed++;
      end
    end
    checks++;
    if (ffs !== 32'd10) $display("FAIL stamp_d4 got %0d want 10", ffs);
    else passed++;
    do_clear();
    checks++;
    if ({ffs, ffs_s} !== 64'd0) $display("FAIL stamp_clr got %0d/%0d want 0/0", ffs, ffs_s);
    else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_overlap();
    test_single();
    test_clr();
    test_enable();
    test_saturate();
    test_midflight_reset();
`ifdef IMPL_DELAY_MONITOR_STAMP_EN
    test_stamp();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/impl_delay_monitor.md
# impl_delay_monitor

Synthesizable checker for the temporal implication "antecedent `a` sampled high at clock edge k requires consequent `b` high at edge k+DELAY."
- Attempts overlap: one new attempt can start every cycle, so up to DELAY attempts are in flight.
- Results are reported as per-attempt pass/fail pulses plus saturating pass/fail counters.
- Sits beside the datapath under test and gives on-chip and FPGA builds the same check the simulation assertions perform.

## Interface
Parameters:
- `DELAY`, 4, cycles from antecedent sample to consequent sample; legal range 1..31.
- `CNT_W`, 16, width of the pass/fail counters.

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `en`  in  1  attempt-start enable; gates `a` only.
- `a`  in  1  antecedent.
- `b`  in  1  consequent.
- `clr`  in  1  synchronous clear of in-flight attempts, counters and sticky flag.
- `pass`  out  1  one-cycle pulse: an attempt matured with `b`=1.
- `fail`  out  1  one-cycle pulse: an attempt matured with `b`=0.
- `pending`  out  DELAY  in-flight attempt vector; bit i set means the attempt started i+1 edges ago.
- `pass_cnt`  out  CNT_W  saturating count of passes.
- `fail_cnt`  out  CNT_W  saturating count of failures.
- `any_fail`  out  1  sticky; set by the first fail.

## Operation
- Attempt register `pend[DELAY-1:0]`, updated every edge: `pend <= {pend[DELAY-2:0], en & a}`. For DELAY=1, `pend <= en & a`.
- Maturing attempt is `pend[DELAY-1]`. On that same edge:
  - `pass <= pend[DELAY-1] & b`
  - `fail <= pend[DELAY-1] & ~b`
- Counters:
  - `pass_cnt` increments on the edge after a `pass` pulse; `fail_cnt` likewise for `fail`.
  - Both hold at 2^CNT_W−1 (no wrap).
- `any_fail` is set when `fail` is 1 and stays set until `clr` or reset.
- `en`=0 blocks new attempts only. Attempts already in `pend` still mature and report.
- `b` is only evaluated for a maturing attempt. `b` with no attempt maturing has no effect.
- Priority order:
  1. `rst_n`=0 forces every register and output to 0.
  2. `clr`=1 does the same, one edge, and also drops the attempt sampled on that edge.
  3. Normal operation.
- No state machine beyond the shift register. Exactly one attempt matures per edge, so `pass` and `fail` are mutually exclusive.

## Timing
- Reset values: `pass`=0, `fail`=0, `pending`=0, `pass_cnt`=0, `fail_cnt`=0, `any_fail`=0.
- Attempt sampled at edge k: `pass`/`fail` is high for the cycle following edge k+DELAY.
- Counters update one edge after the pulse, i.e. after edge k+DELAY+1.
- `clr` or reset in mid-flight discards every pending attempt with no pass/fail reported. The first reportable result after release is from an attempt sampled at least one edge after release.
- Back-to-back `a` produces back-to-back results, one per cycle, in start order.

## Configuration
- Macro `IMPL_DELAY_MONITOR_STAMP_EN`.
- **Defined:** adds
  - a free-running 32-bit cycle counter `cyc`, cleared by reset only, wrapping;
  - output `first_fail_start[31:0]`, which latches `cyc − DELAY − 1` (modulo 2^32, the start edge of the offending attempt) on the first `fail` pulse after reset or `clr`. It holds until `clr` or reset and resets to 0.
- **Undefined:** no `cyc` counter and no `first_fail_start` port; all other behaviour is identical.

## Structure
- Package `impl_delay_monitor_pkg` holds:
  - `MAX_DELAY` = 31;
  - `STAMP_W` = 32;
  - a `mon_result_t` struct {pass, fail}.
- Sub-module `sat_counter` (parameter W; inputs `inc`, `clr`; saturating output), instantiated twice, for pass and fail.

## Test plan
1. DELAY=4, `en`=1, `a`=1 for edges 0–5, `b`=1 only at edges 6–7 → pulses fail, fail, pass, pass, fail, fail after edges 4–9; `pass_cnt`=2, `fail_cnt`=4, `any_fail`=1.
2. Single `a` at edge 3 and `b`=1 at edge 7 only → one `pass` after edge 7; `pending` shows bits 0..3 walking through edges 3–6; no `fail`.
3. `a`=1 at edges 0–2, `clr` at edge 2 → `pending`=0 after edge 2, no pass/fail ever reported, counters stay 0.
4. `en`=0 with `a` toggling for 20 cycles → no pulses. Then `en`=0 applied one edge after a sampled attempt → that attempt still reports at edge+DELAY.
5. CNT_W=3, `a`=`b`=1 for 12 edges → `pass_cnt` stops at 7, `fail_cnt`=0.
6. STAMP_EN defined, DELAY=2, `a` at edges 10 and 11, `b`=0 at edges 12–13 → `first_fail_start`=10; the second fail leaves it unchanged; `clr` returns it to 0.
